// File: rtl/ipdc_host_if.sv
// rtl/ipdc_host_if.sv - command, pixel source, ipdc op/stream and result signals of ipdc_host
interface ipdc_host_if;
  logic        i_cmd_valid;
  logic [2:0]  i_cmd_mode;
  logic        o_cmd_ready;
  logic [5:0]  o_pix_addr;
  logic [23:0] i_pix_data;
  logic        o_op_valid;
  logic [2:0]  o_op_mode;
  logic        o_in_valid;
  logic [23:0] o_in_data;
  logic        i_in_ready;
  logic        i_out_valid;
  logic [23:0] i_out_data;
  logic        o_res_valid;
  logic [3:0]  o_res_idx;
  logic [23:0] o_res_data;
  logic        o_done;
  logic        o_err;

  // master is the host sequencer, slave is the command source / pixel memory / ipdc side
  modport master (
    input  i_cmd_valid, i_cmd_mode, i_pix_data, i_in_ready, i_out_valid, i_out_data,
    output o_cmd_ready, o_pix_addr, o_op_valid, o_op_mode, o_in_valid, o_in_data,
    output o_res_valid, o_res_idx, o_res_data, o_done, o_err
  );

  modport slave (
    output i_cmd_valid, i_cmd_mode, i_pix_data, i_in_ready, i_out_valid, i_out_data,
    input  o_cmd_ready, o_pix_addr, o_op_valid, o_op_mode, o_in_valid, o_in_data,
    input  o_res_valid, o_res_idx, o_res_data, o_done, o_err
  );
endinterface

// File: rtl/ipdc_host.sv
// rtl/ipdc_host.sv - ipdc host sequencer: op issue, 64-pixel load, result capture, watchdog
module ipdc_host #(
  parameter int TIMEOUT = 4095
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  ipdc_host_if.master bus
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, LOAD, WAIT_ACK, COLLECT, FINISH} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [2:0]      mode_q;
  logic [6:0]      pix_idx;
  logic [3:0]      res_cnt;
  logic [WD_W-1:0] wd_cnt;
  logic            in_valid_q;
  logic [23:0]     in_data_q;
  logic            res_valid_q;
  logic [3:0]      res_idx_q;
  logic [23:0]     res_data_q;
  logic            err_q;

  logic cmd_fire;
  logic in_fire;
  logic last_pix;
  logic watching;
  logic wd_expire;

  assign cmd_fire  = bus.i_cmd_valid && bus.o_cmd_ready;
  assign in_fire   = in_valid_q && bus.i_in_ready;
  // pix_idx counts pixels already loaded into o_in_data, so 64 means pixel 63 is on the bus
  assign last_pix  = (pix_idx == 7'd64);
  assign watching  = (state == WAIT_ACK) || (state == COLLECT);
  assign wd_expire = watching && !bus.i_out_valid && (wd_cnt == WD_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (cmd_fire) state_nxt = ISSUE;
      ISSUE: begin
        if (mode_q == 3'd0)      state_nxt = LOAD;
        else if (mode_q <= 3'd4) state_nxt = COLLECT;
        else                     state_nxt = WAIT_ACK;
      end
      LOAD:     if (in_fire && last_pix) state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (bus.i_out_valid) state_nxt = FINISH;
        else if (wd_expire)  state_nxt = IDLE;
      end
      COLLECT: begin
        if (bus.i_out_valid && res_cnt == 4'd15) state_nxt = FINISH;
        else if (wd_expire)                      state_nxt = IDLE;
      end
      FINISH:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q      <= 3'd0;
      pix_idx     <= 7'd0;
      res_cnt     <= 4'd0;
      wd_cnt      <= '0;
      in_valid_q  <= 1'b0;
      in_data_q   <= 24'd0;
      res_valid_q <= 1'b0;
      res_idx_q   <= 4'd0;
      res_data_q  <= 24'd0;
      err_q       <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      err_q       <= wd_expire;
      if (cmd_fire) mode_q <= bus.i_cmd_mode;
      // a state change (entry or exit) or any out_valid restarts the watchdog
      if (watching && !bus.i_out_valid && state_nxt == state) wd_cnt <= wd_cnt + 1'b1;
      else                                                     wd_cnt <= '0;
      case (state)
        IDLE: begin
          pix_idx <= 7'd0;
          res_cnt <= 4'd0;
        end
        ISSUE: begin
          if (mode_q == 3'd0) begin
            in_valid_q <= 1'b1;
            in_data_q  <= bus.i_pix_data;
            pix_idx    <= 7'd1;
          end
        end
        LOAD: begin
          if (in_fire) begin
            if (last_pix) begin
              in_valid_q <= 1'b0;
              in_data_q  <= 24'd0;
            end else begin
              in_data_q <= bus.i_pix_data;
              pix_idx   <= pix_idx + 7'd1;
            end
          end
        end
        COLLECT: begin
          if (bus.i_out_valid) begin
            res_valid_q <= 1'b1;
            res_idx_q   <= res_cnt;
            res_data_q  <= bus.i_out_data;
            res_cnt     <= res_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_cmd_ready = (state == IDLE) && i_rst_n;
  assign bus.o_pix_addr  = pix_idx[5:0];
  assign bus.o_op_valid  = (state == ISSUE);
  assign bus.o_op_mode   = (state == ISSUE) ? mode_q : 3'd0;
  assign bus.o_in_valid  = in_valid_q;
  assign bus.o_in_data   = in_data_q;
  assign bus.o_res_valid = res_valid_q;
  assign bus.o_res_idx   = res_idx_q;
  assign bus.o_res_data  = res_data_q;
  assign bus.o_done      = (state == FINISH);
  assign bus.o_err       = err_q;
endmodule

// File: tb/tb_ipdc_host.sv
// tb/tb_ipdc_host.sv - directed self-checking bench for ipdc_host
module tb_ipdc_host;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [2:0] b2b_modes [3] = '{3'd0, 3'd1, 3'd5};
  logic [2:0] got_modes [3];
  int         gaps [16] = '{0, 3, 1, 5, 2, 0, 4, 1, 0, 5, 3, 2, 1, 0, 4, 2};

  always #5 clk = ~clk;

  ipdc_host_if bus ();

  ipdc_host #(.TIMEOUT(4095)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  // asynchronous pixel source: pixel[k] = k * 0x010101
  assign bus.i_pix_data = {2'b00, bus.o_pix_addr, 2'b00, bus.o_pix_addr, 2'b00, bus.o_pix_addr};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_cmd(input logic [2:0] mode);
    int n;
    n = 0;
    while (!bus.o_cmd_ready && n < 20) begin
      tick();
      n++;
    end
    chk("cmd_ready", 32'(bus.o_cmd_ready), 32'd1);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_mode  = mode;
    tick();
    bus.i_cmd_valid = 1'b0;
    chk("op_valid", 32'(bus.o_op_valid), 32'd1);
    chk("op_mode", 32'(bus.o_op_mode), 32'(mode));
    tick();
    chk("op_valid_one_cycle", 32'(bus.o_op_valid), 32'd0);
    chk("op_mode_zero", 32'(bus.o_op_mode), 32'd0);
  endtask

  task automatic run_load(input bit stall);
    int e;
    int cyc;
    start_cmd(3'd0);
    e = 0;
    cyc = 0;
    while (e < 64 && cyc < 300) begin
      bus.i_in_ready = stall ? (cyc % 3 != 2) : 1'b1;
      chk("in_valid", 32'(bus.o_in_valid), 32'd1);
      chk("in_data", 32'(bus.o_in_data), 32'(e * 32'h010101));
      if (bus.i_in_ready) e++;
      cyc++;
      tick();
    end
    bus.i_in_ready = 1'b1;
    chk("load_count", 32'(e), 32'd64);
    if (!stall) chk("load_cycles", 32'(cyc), 32'd64);
    chk("in_valid_end", 32'(bus.o_in_valid), 32'd0);
    chk("in_data_end", 32'(bus.o_in_data), 32'd0);
  endtask

  task automatic ack_and_finish();
    tick();
    tick();
    chk("no_early_done", 32'(bus.o_done), 32'd0);
    bus.i_out_valid = 1'b1;
    bus.i_out_data  = 24'h123456;
    tick();
    bus.i_out_valid = 1'b0;
    chk("ack_done", 32'(bus.o_done), 32'd1);
    chk("ack_no_res", 32'(bus.o_res_valid), 32'd0);
    tick();
    chk("done_one_cycle", 32'(bus.o_done), 32'd0);
    chk("ready_after_done", 32'(bus.o_cmd_ready), 32'd1);
  endtask

  initial begin
    int cyc;
    int ndone;
    int nacc;
    int nres;
    int npix;
    int bad_mode;
    int bad_res;
    bit seen_done;

    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_mode  = 3'd0;
    bus.i_in_ready  = 1'b1;
    bus.i_out_valid = 1'b0;
    bus.i_out_data  = 24'd0;

    // reset state
    repeat (3) tick();
    chk("rst_cmd_ready", 32'(bus.o_cmd_ready), 32'd0);
    chk("rst_op_valid", 32'(bus.o_op_valid), 32'd0);
    chk("rst_in_valid", 32'(bus.o_in_valid), 32'd0);
    chk("rst_res_valid", 32'(bus.o_res_valid), 32'd0);
    chk("rst_done_err", 32'({bus.o_done, bus.o_err}), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(bus.o_cmd_ready), 32'd1);

    // full-rate load, ack three cycles later
    run_load(1'b0);
    ack_and_finish();

    // load with in_ready low every third cycle
    run_load(1'b1);
    ack_and_finish();

    // out_valid in IDLE is ignored
    bus.i_out_valid = 1'b1;
    tick();
    bus.i_out_valid = 1'b0;
    chk("idle_out_ignored", 32'(bus.o_res_valid), 32'd0);
    chk("idle_stays_ready", 32'(bus.o_cmd_ready), 32'd1);

    // display collect with gaps
    start_cmd(3'd2);
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        tick();
        chk("gap_no_res", 32'(bus.o_res_valid), 32'd0);
      end
      bus.i_out_valid = 1'b1;
      bus.i_out_data  = 24'hA00000 + 24'(i);
      tick();
      bus.i_out_valid = 1'b0;
      chk("res_valid", 32'(bus.o_res_valid), 32'd1);
      chk("res_idx", 32'(bus.o_res_idx), 32'(i));
      chk("res_data", 32'(bus.o_res_data), 32'h00A00000 + 32'(i));
      if (i < 15) chk("collect_no_done", 32'(bus.o_done), 32'd0);
    end
    ndone = 0;
    for (int k = 0; k < 3; k++) begin
      if (bus.o_done) ndone++;
      if (k < 2) tick();
    end
    chk("collect_done_once", 32'(ndone), 32'd1);
    tick();
    chk("collect_ready_back", 32'(bus.o_cmd_ready), 32'd1);

    // process mode with no ack: watchdog
    start_cmd(3'd6);
    cyc = 0;
    seen_done = 1'b0;
    while (!bus.o_err && cyc < 5000) begin
      tick();
      cyc++;
      if (bus.o_done) seen_done = 1'b1;
    end
    chk("timeout_latency", 32'(cyc), 32'd4095);
    chk("timeout_err", 32'(bus.o_err), 32'd1);
    chk("timeout_no_done", 32'(seen_done), 32'd0);
    chk("timeout_ready", 32'(bus.o_cmd_ready), 32'd1);
    tick();
    chk("err_one_cycle", 32'(bus.o_err), 32'd0);

    // reset after pixel 20 accepted
    start_cmd(3'd0);
    for (int e = 0; e < 21; e++) begin
      chk("pre_rst_data", 32'(bus.o_in_data), 32'(e * 32'h010101));
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_valid", 32'(bus.o_in_valid), 32'd0);
    chk("midrst_in_data", 32'(bus.o_in_data), 32'd0);
    chk("midrst_addr", 32'(bus.o_pix_addr), 32'd0);
    chk("midrst_done_err", 32'({bus.o_done, bus.o_err}), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_load(1'b0);
    ack_and_finish();

    // back-to-back commands with cmd_valid held and out_valid always high
    nacc = 0; ndone = 0; nres = 0; npix = 0; bad_mode = 0; bad_res = 0; cyc = 0;
    bus.i_in_ready  = 1'b1;
    bus.i_out_valid = 1'b1;
    bus.i_out_data  = 24'hB00000;
    bus.i_cmd_mode  = b2b_modes[0];
    bus.i_cmd_valid = 1'b1;
    while (ndone < 3 && cyc < 500) begin
      tick();
      cyc++;
      if (bus.o_op_valid) begin
        if (nacc < 3) got_modes[nacc] = bus.o_op_mode;
        nacc++;
        if (nacc < 3) bus.i_cmd_mode = b2b_modes[nacc];
        else          bus.i_cmd_valid = 1'b0;
      end else if (bus.o_op_mode != 3'd0) begin
        bad_mode++;
      end
      if (bus.o_in_valid) npix++;
      if (bus.o_res_valid) begin
        if (bus.o_res_idx != nres[3:0]) bad_res++;
        if (bus.o_res_data != 24'hB00000 + 24'(cyc - 1)) bad_res++;
        nres++;
      end
      if (bus.o_done) ndone++;
      bus.i_out_data = 24'hB00000 + 24'(cyc);
    end
    bus.i_out_valid = 1'b0;
    bus.i_cmd_valid = 1'b0;
    chk("b2b_accepts", 32'(nacc), 32'd3);
    chk("b2b_mode0", 32'(got_modes[0]), 32'd0);
    chk("b2b_mode1", 32'(got_modes[1]), 32'd1);
    chk("b2b_mode2", 32'(got_modes[2]), 32'd5);
    chk("b2b_dones", 32'(ndone), 32'd3);
    chk("b2b_pixels", 32'(npix), 32'd64);
    chk("b2b_results", 32'(nres), 32'd16);
    chk("b2b_res_content", 32'(bad_res), 32'd0);
    chk("b2b_op_mode_idle", 32'(bad_mode), 32'd0);
    tick();
    chk("b2b_ready_end", 32'(bus.o_cmd_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ipdc_host.md
IPDC_HOST -- requirements
Module: ipdc_host

Interface
REQ-001 SHALL have parameter TIMEOUT, default 4095, max cycles to wait for an ipdc out_valid before aborting.
REQ-002 SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_cmd_valid  input  1  host command request.
REQ-005 SHALL have port i_cmd_mode  input  3  ipdc op mode for the command.
REQ-006 SHALL have port o_cmd_ready  output  1  high only in IDLE; command accepted when i_cmd_valid & o_cmd_ready.
REQ-007 SHALL have port o_pix_addr  output  6  pixel source read address; source data is valid in the same cycle (asynchronous read).
REQ-008 SHALL have port i_pix_data  input  24  pixel source read data.
REQ-009 SHALL have port o_op_valid, o_op_mode  output  1/3  ipdc op issue.
REQ-010 SHALL have port o_in_valid, o_in_data  output  1/24  ipdc pixel stream.
REQ-011 SHALL have port i_in_ready  input  1  ipdc ready for pixels.
REQ-012 SHALL have port i_out_valid, i_out_data  input  1/24  ipdc result stream.
REQ-013 SHALL have port o_res_valid, o_res_idx, o_res_data  output  1/4/24  captured display result, index 0..15.
REQ-014 SHALL have port o_done, o_err  output  1/1  one-cycle completion / timeout pulses.

Function
REQ-015 Mode classes SHALL be: 0 = LOAD (64 pixels), 1-4 = DISPLAY (16 results), 5-7 = PROCESS (one out_valid acknowledge).
REQ-016 FSM states SHALL be IDLE, ISSUE, LOAD, WAIT_ACK, COLLECT, FINISH.
REQ-017 IDLE -> ISSUE on accepted command; mode latched; other inputs ignored while busy.
REQ-018 ISSUE: o_op_valid=1 and o_op_mode=latched mode for exactly one cycle; o_op_mode=0 whenever o_op_valid=0.
REQ-019 ISSUE -> LOAD for mode 0, -> COLLECT for 1-4, -> WAIT_ACK for 5-7.
REQ-020 LOAD: first pixel (index 0) SHALL be driven with o_in_valid=1 in the cycle immediately after the op_valid cycle.
REQ-021 LOAD: pixel k SHALL be held on o_in_data until a rising edge with o_in_valid & i_in_ready; then pixel k+1 is driven; order 0..63 strictly.
REQ-022 o_pix_addr SHALL equal the index whose data is loaded into o_in_data next; o_in_data is registered.
REQ-023 After pixel 63 is accepted, o_in_valid=0, o_in_data=0 in the next cycle, and state -> WAIT_ACK.
REQ-024 WAIT_ACK: first cycle with i_out_valid=1 -> FINISH.
REQ-025 COLLECT: each cycle with i_out_valid=1 SHALL produce, one cycle later, o_res_valid=1, o_res_data=i_out_data, o_res_idx=running count (0..15); gaps between out_valid cycles are allowed.
REQ-026 COLLECT -> FINISH the cycle after the 16th result is captured; further i_out_valid ignored.
REQ-027 FINISH: o_done=1 for one cycle, -> IDLE; o_cmd_ready high again the next cycle.
REQ-028 Watchdog: cycle counter cleared on entry to WAIT_ACK/COLLECT and on every i_out_valid; if it reaches TIMEOUT, o_err=1 one cycle, o_done stays 0, -> IDLE.
REQ-029 i_out_valid in IDLE, ISSUE or LOAD SHALL be ignored (no o_res_valid, no state change).
REQ-030 i_in_ready low throughout LOAD SHALL stall indefinitely (no watchdog in LOAD).

Reset
REQ-031 On i_rst_n=0, asynchronously: state=IDLE, counters=0, all outputs 0 except o_cmd_ready, which is 1 once reset deasserts.
REQ-032 Reset mid-LOAD or mid-COLLECT SHALL abort with no o_done/o_err pulse; next command restarts from pixel 0 / index 0.

Verification
REQ-033 Mode 0, i_in_ready=1, pixel[k]=k*0x010101: op_valid 1 cycle, then 64 consecutive in_valid cycles with data 0x000000..0x3F3F3F, model out_valid after 3 cycles -> o_done 1 cycle later.
REQ-034 Mode 0 with i_in_ready low on every third cycle -> same 64-word sequence, no duplicates/skips, o_in_data stable while stalled.
REQ-035 Mode 2, model emits 16 results 0xA00000+i with random 0-5 cycle gaps -> o_res_idx 0..15, matching data, o_done once.
REQ-036 Mode 6, out_valid never asserted, TIMEOUT=4095 -> o_err pulse 4095 cycles after WAIT_ACK entry, o_cmd_ready returns.
REQ-037 Reset asserted after pixel 20 accepted -> outputs 0 immediately; new mode 0 command restarts at pixel 0.
REQ-038 i_cmd_valid held high with modes 0,1,5 back-to-back -> each accepted only in IDLE, executed in order, three o_done pulses.
